// File: rtl/fixed_denorm_pkg.sv
// Shared constants and types for the fixed-point denormaliser.
// SHIFT_W matches the LZC count width used by lzc and the reciprocal block.
package fixed_denorm_pkg;

  localparam int unsigned SHIFT_W     = 7;
  localparam int unsigned GUARD_W     = 8;
  localparam int unsigned FINE_W      = 3;
  localparam int unsigned COARSE_W    = SHIFT_W - FINE_W;
  localparam int unsigned COARSE_GRAN = 1 << FINE_W;

  typedef enum logic {
    DirRight = 1'b0,
    DirLeft  = 1'b1
  } shift_dir_e;

endpackage

// File: rtl/denorm_shift_stage.sv
// Barrel shift by amt*GRANULE, returning the top OUT_W bits of the IN_W-wide result
// plus a flag for any set input bit pushed off the end in the shift direction.
module denorm_shift_stage
  import fixed_denorm_pkg::*;
#(
  parameter int unsigned IN_W    = 40,
  parameter int unsigned OUT_W   = 40,
  parameter int unsigned GRANULE = 8,
  parameter int unsigned AMT_W   = 4
) (
  input  logic [IN_W-1:0]  data,
  input  logic [AMT_W-1:0] amt,
  input  shift_dir_e       dir,
  output logic [OUT_W-1:0] result,
  output logic             lost
);

  localparam int unsigned SHAMT_W = AMT_W + 4;
  localparam int unsigned DROP    = IN_W - OUT_W;
  localparam logic [IN_W-1:0] ONES = '1;

  logic [SHAMT_W-1:0] shamt;
  logic [IN_W-1:0]    keep;

  always_comb begin
    shamt = SHAMT_W'(amt) * SHAMT_W'(GRANULE);
    if (dir == DirLeft) begin
      result = OUT_W'((data << shamt) >> DROP);
      keep   = ONES >> shamt;
    end else begin
      // Dropping the low DROP bits is folded into the right shift itself.
      result = OUT_W'(data >> (shamt + SHAMT_W'(DROP)));
      keep   = ONES << shamt;
    end
    lost = |(data & ~keep);
  end

endmodule

// File: rtl/fixed_denorm.sv
// Two-stage denormaliser: S1 coarse shift by multiples of 8, S2 fine shift with
// round-half-up (right) or saturation (left). Valid/ready on both sides.
module fixed_denorm
  import fixed_denorm_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter bit          ROUND = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_mant,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               in_shl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_ovf
);

  localparam int unsigned EW = WIDTH + GUARD_W;

  logic              s1_valid;
  logic [EW-1:0]     s1_vec;
  logic [FINE_W-1:0] s1_fine;
  shift_dir_e        s1_dir;
  logic              s1_lost;

  logic              s2_open;
  logic              s1_adv;
  logic              in_fire;
  shift_dir_e        in_dir;

  logic [EW-1:0]     c_vec;
  logic              c_lost;
  logic [WIDTH:0]    f_vec;
  logic              f_lost;

  logic              round_bit;
  logic [WIDTH-1:0]  res_d;
  logic              ovf_d;

  always_comb begin
    s2_open  = ~out_valid | out_ready;
    s1_adv   = s1_valid & s2_open;
    in_ready = ~s1_valid | s1_adv;
    in_fire  = in_valid & in_ready;
    in_dir   = shift_dir_e'(in_shl);
  end

  // Guard bits below the LSB keep the round bit alive through the coarse right shift.
  denorm_shift_stage #(
    .IN_W    (EW),
    .OUT_W   (EW),
    .GRANULE (COARSE_GRAN),
    .AMT_W   (COARSE_W)
  ) u_coarse (
    .data   ({in_mant, {GUARD_W{1'b0}}}),
    .amt    (in_shift[SHIFT_W-1:FINE_W]),
    .dir    (in_dir),
    .result (c_vec),
    .lost   (c_lost)
  );

  // Only the mantissa and the single bit below it survive the fine stage.
  denorm_shift_stage #(
    .IN_W    (EW),
    .OUT_W   (WIDTH + 1),
    .GRANULE (1),
    .AMT_W   (FINE_W)
  ) u_fine (
    .data   (s1_vec),
    .amt    (s1_fine),
    .dir    (s1_dir),
    .result (f_vec),
    .lost   (f_lost)
  );

  always_comb begin
    round_bit = ROUND && (s1_dir == DirRight) && f_vec[0];
    res_d     = f_vec[WIDTH:1] + WIDTH'(round_bit);
    ovf_d     = 1'b0;
    if ((s1_dir == DirLeft) && (s1_lost || f_lost)) begin
      res_d = '1;
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
      s1_fine  <= '0;
      s1_dir   <= DirRight;
      s1_lost  <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_fire) begin
        s1_vec  <= c_vec;
        s1_fine <= in_shift[FINE_W-1:0];
        s1_dir  <= in_dir;
        s1_lost <= c_lost;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (s2_open) begin
        out_valid <= s1_valid;
      end
      if (s1_adv) begin
        out_data <= res_d;
        out_ovf  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_fixed_denorm.sv
// Self-checking bench for fixed_denorm: ROUND=1 and ROUND=0 instances in lockstep,
// scoreboard queues filled on accept and drained on output transfer.
module tb_fixed_denorm;

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_mant = '0;
  logic [6:0]  in_shift = '0;
  logic        in_shl = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_ovf;
  logic [31:0] out_data;
  logic        in_ready_t, out_valid_t, out_ovf_t;
  logic [31:0] out_data_t;

  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  exp_t q_r[$];
  exp_t q_t[$];

  always #5 clk = ~clk;

  fixed_denorm #(.WIDTH(32), .ROUND(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_shift(in_shift), .in_shl(in_shl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  fixed_denorm #(.WIDTH(32), .ROUND(1'b0)) dut_t (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_t),
    .in_mant(in_mant), .in_shift(in_shift), .in_shl(in_shl),
    .out_valid(out_valid_t), .out_ready(out_ready), .out_data(out_data_t),
    .out_ovf(out_ovf_t)
  );

  function automatic exp_t model(input logic [31:0] m, input logic [6:0] s, input logic l,
                                 input bit rnd);
    exp_t e;
    logic [63:0] full;
    int sh;
    sh = int'(s);
    e.ovf = 1'b0;
    if (l) begin
      full = {32'h0, m} << sh;
      if (m != 0 && (sh >= 32 || full[63:32] != 0)) begin
        e.data = 32'hFFFF_FFFF;
        e.ovf  = 1'b1;
      end else begin
        e.data = full[31:0];
      end
    end else begin
      e.data = (sh >= 32) ? 32'h0 : (m >> sh);
      if (rnd && sh >= 1 && sh <= 32) e.data = e.data + {31'h0, m[sh-1]};
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_mant();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 255));
      2: return 32'hFFFF_FFFF;
      default: return 32'h1 << $urandom_range(0, 31);
    endcase
  endfunction

  function automatic logic [6:0] rand_shift();
    if ($urandom_range(0, 1) == 0) return 7'($urandom_range(0, 127));
    return 7'($urandom_range(0, 40));
  endfunction

  // Scoreboard
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (in_valid && in_ready) begin
        q_r.push_back(model(in_mant, in_shift, in_shl, 1'b1));
        q_t.push_back(model(in_mant, in_shift, in_shl, 1'b0));
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q_r.size() == 0) begin
          n_fail++;
          $display("FAIL sb_round: unexpected output data=%h ovf=%b", out_data, out_ovf);
        end else begin
          exp_t e;
          e = q_r.pop_front();
          if ({out_data, out_ovf} !== {e.data, e.ovf}) begin
            n_fail++;
            $display("FAIL sb_round: got %h/%b expected %h/%b", out_data, out_ovf, e.data, e.ovf);
          end
        end
      end
      if (out_valid_t && out_ready) begin
        n_checks++;
        if (q_t.size() == 0) begin
          n_fail++;
          $display("FAIL sb_trunc: unexpected output data=%h", out_data_t);
        end else begin
          exp_t e;
          e = q_t.pop_front();
          if ({out_data_t, out_ovf_t} !== {e.data, e.ovf}) begin
            n_fail++;
            $display("FAIL sb_trunc: got %h/%b expected %h/%b", out_data_t, out_ovf_t,
                     e.data, e.ovf);
          end
        end
      end
    end
  end

  // Drive one item and capture the first result; leaves at posedge+1.
  task automatic send(input logic [31:0] m, input logic [6:0] s, input logic l,
                      output bit got, output logic [31:0] d, output logic o,
                      output logic [31:0] dt);
    bit acc;
    got = 1'b0; d = '0; o = 1'b0; dt = '0;
    in_mant = m; in_shift = s; in_shl = l; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (acc) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (out_valid) begin
          got = 1'b1; d = out_data; o = out_ovf; dt = out_data_t;
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ovf !== 1'b0 || out_valid_t !== 1'b0)
    begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%h o=%b required v=0 d=0 o=0",
               out_valid, out_data, out_ovf);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    in_mant = 32'h8000_0000; in_shift = 7'd4; in_shl = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_accept: in_ready got %b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_early: out_valid got %b required 0 one cycle after accept", out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0800_0000 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_result: got v=%b d=%h o=%b required v=1 d=08000000 o=0",
               out_valid, out_data, out_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_left();
    logic [31:0] sh_mant[4] = '{32'h3, 32'h3, 32'h0, 32'hDEAD_BEEF};
    logic [6:0]  sh_amt[4]  = '{7'd30, 7'd31, 7'd100, 7'd0};
    logic [31:0] ex_d[4]    = '{32'hC000_0000, 32'hFFFF_FFFF, 32'h0, 32'hDEAD_BEEF};
    logic        ex_o[4]    = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit got; logic [31:0] d, dt; logic o;
    for (int i = 0; i < 4; i++) begin
      send(sh_mant[i], sh_amt[i], 1'b1, got, d, o, dt);
      n_checks++;
      if (!got || d !== ex_d[i] || o !== ex_o[i] || dt !== ex_d[i]) begin
        n_fail++;
        $display("FAIL left_%0d: got v=%b d=%h o=%b dt=%h required d=%h o=%b",
                 i, got, d, o, dt, ex_d[i], ex_o[i]);
      end
    end
  endtask

  task automatic test_right();
    logic [31:0] sh_mant[4] = '{32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [6:0]  sh_amt[4]  = '{7'd1, 7'd32, 7'd40, 7'd0};
    logic [31:0] ex_r[4]    = '{32'h2, 32'h1, 32'h0, 32'h1234_5678};
    logic [31:0] ex_t[4]    = '{32'h1, 32'h0, 32'h0, 32'h1234_5678};
    bit got; logic [31:0] d, dt; logic o;
    for (int i = 0; i < 4; i++) begin
      send(sh_mant[i], sh_amt[i], 1'b0, got, d, o, dt);
      n_checks++;
      if (!got || d !== ex_r[i] || o !== 1'b0 || dt !== ex_t[i]) begin
        n_fail++;
        $display("FAIL right_%0d: got v=%b d=%h o=%b dt=%h required d=%h o=0 dt=%h",
                 i, got, d, o, dt, ex_r[i], ex_t[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t ex[10];
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i < 10) begin
        in_valid = 1'b1;
        in_mant  = rand_mant();
        in_shift = rand_shift();
        in_shl   = 1'($urandom_range(0, 1));
        ex[i]    = model(in_mant, in_shift, in_shl, 1'b1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 10) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready_%0d: in_ready got %b required 1", i, in_ready);
        end
      end
      n_checks++;
      if (out_valid !== (i >= 2 && i <= 11)) begin
        n_fail++;
        $display("FAIL b2b_valid_%0d: out_valid got %b required %b", i, out_valid,
                 (i >= 2 && i <= 11));
      end else if (i >= 2 && i <= 11 && {out_data, out_ovf} !== {ex[i-2].data, ex[i-2].ovf})
      begin
        n_fail++;
        $display("FAIL b2b_data_%0d: got %h/%b required %h/%b", i, out_data, out_ovf,
                 ex[i-2].data, ex[i-2].ovf);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    logic [31:0] ex_d[3] = '{32'h0012_3456, 32'h0ABC_D000, 32'hFFFF_FFFF};
    logic        ex_o[3] = '{1'b0, 1'b0, 1'b1};
    out_ready = 1'b0;
    in_valid = 1'b1; in_mant = 32'h1234_5678; in_shift = 7'd8; in_shl = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_acc_a: in_ready got %b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_mant = 32'h0000_ABCD; in_shift = 7'd12; in_shl = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_acc_b: in_ready got %b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_mant = 32'hFFFF_0000; in_shift = 7'd1; in_shl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== ex_d[0] || out_ovf !== 1'b0)
      begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got rdy=%b v=%b d=%h required rdy=0 v=1 d=%h",
                 i, in_ready, out_valid, out_data, ex_d[0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_acc_c: in_ready got %b required 1", in_ready);
        end
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== ex_d[i] || out_ovf !== ex_o[i]) begin
        n_fail++;
        $display("FAIL stall_drain_%0d: got v=%b d=%h o=%b required v=1 d=%h o=%b",
                 i, out_valid, out_data, out_ovf, ex_d[i], ex_o[i]);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_empty: out_valid got %b required 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit acc = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_mant  = rand_mant();
        in_shift = rand_shift();
        in_shl   = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (q_r.size() != 0 || q_t.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: pending %0d/%0d results required 0", q_r.size(), q_t.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mant = 32'h0F0F_0F0F; in_shift = 7'd3; in_shl = 1'b0;
    @(posedge clk); #1;
    in_mant = 32'h0000_00FF; in_shift = 7'd9; in_shl = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_full: got v=%b rdy=%b required v=1 rdy=0", out_valid, in_ready);
    end
    #1;
    reset = 1'b1;
    q_r.delete();
    q_t.delete();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_valid_t !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: out_valid got %b/%b required 0", out_valid, out_valid_t);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_after_%0d: got rdy=%b v=%b required rdy=1 v=0",
                 i, in_ready, out_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_left();
    test_right();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
